// File: rtl/speed_to_bin.sv
// speed_to_bin: counts encoder edges over a fixed window, quantises to {dir, code}.
// Ports: clk, reset (sync high), en, tick, dir -> bin_speed, real_speed, valid.
module speed_to_bin #(
  parameter int width       = 32,
  parameter int MAX_SPEED   = 1000,
  parameter int SPEED_ONE   = MAX_SPEED / 3,
  parameter int SPEED_TWO   = MAX_SPEED / 2,
  parameter int SPEED_THREE = MAX_SPEED,
  parameter int WINDOW      = 4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             tick,
  input  logic             dir,
  output logic [2:0]       bin_speed,
  output logic [width-1:0] real_speed,
  output logic             valid
);

  localparam int WW = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  localparam logic [WW-1:0] W_LAST = WW'(WINDOW - 1);

  // Midpoints between nominal speeds; a count on a midpoint rounds up.
  localparam logic [width-1:0] T1 = width'(SPEED_ONE / 2);
  localparam logic [width-1:0] T2 = width'((SPEED_ONE + SPEED_TWO) / 2);
  localparam logic [width-1:0] T3 = width'((SPEED_TWO + SPEED_THREE) / 2);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    REPORT
  } state_t;

  state_t           state;
  logic [WW-1:0]    wcnt;
  logic [width-1:0] cnt;
  logic [width-1:0] cnt_inc;
  logic             tick_q;
  logic             dir_q;
  logic             edge_hit;
  logic [1:0]       code;

  always_comb begin
    edge_hit = tick & ~tick_q;
    cnt_inc  = cnt;
    // Saturate rather than wrap so a runaway encoder reads as full scale.
    if (edge_hit && (cnt != '1)) begin
      cnt_inc = cnt + width'(1);
    end
    code = 2'd0;
    if (cnt_inc >= T3) begin
      code = 2'd3;
    end else if (cnt_inc >= T2) begin
      code = 2'd2;
    end else if (cnt_inc >= T1) begin
      code = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wcnt       <= '0;
      cnt        <= '0;
      tick_q     <= 1'b0;
      dir_q      <= 1'b0;
      bin_speed  <= 3'b000;
      real_speed <= '0;
      valid      <= 1'b0;
    end else begin
      tick_q <= tick;
      valid  <= 1'b0;
      unique case (state)
        IDLE: begin
          wcnt <= '0;
          cnt  <= '0;
          if (en) begin
            state <= MEASURE;
            dir_q <= dir;
          end
        end
        MEASURE: begin
          if (!en) begin
            state <= IDLE;
            wcnt  <= '0;
            cnt   <= '0;
          end else if (dir != dir_q) begin
            // Direction reversal: the partial window is meaningless.
            wcnt  <= '0;
            cnt   <= '0;
            dir_q <= dir;
          end else if (wcnt == W_LAST) begin
            state      <= REPORT;
            real_speed <= cnt_inc;
            bin_speed  <= {dir_q, code};
            valid      <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
            cnt  <= cnt_inc;
          end
        end
        REPORT: begin
          // This cycle is cycle 0 of the next window.
          dir_q <= dir;
          if (en) begin
            state <= MEASURE;
            wcnt  <= WW'(1);
            cnt   <= edge_hit ? width'(1) : '0;
          end else begin
            state <= IDLE;
            wcnt  <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speed_to_bin.sv
// tb_speed_to_bin: windowed speed quantiser bench.
// Per-cycle model compare plus directed literal checks.
module tb_speed_to_bin;

  localparam int W   = 32;
  localparam int MS  = 60;
  localparam int WIN = 100;
  localparam int S1  = MS / 3;
  localparam int S2  = MS / 2;
  localparam int S3  = MS;
  localparam int T1  = S1 / 2;
  localparam int T2  = (S1 + S2) / 2;
  localparam int T3  = (S2 + S3) / 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         tick;
  logic         dir;
  logic [2:0]   bin_speed;
  logic [W-1:0] real_speed;
  logic         valid;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  speed_to_bin #(
    .width    (W),
    .MAX_SPEED(MS),
    .WINDOW   (WIN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .tick      (tick),
    .dir       (dir),
    .bin_speed (bin_speed),
    .real_speed(real_speed),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: a window is WIN consecutive counted cycles; a report cycle
  // is the first counted cycle of the following window.
  function automatic logic [1:0] quant(int c);
    if (c >= T3) return 2'd3;
    if (c >= T2) return 2'd2;
    if (c >= T1) return 2'd1;
    return 2'd0;
  endfunction

  bit         m_act   = 1'b0;
  bit         m_rep   = 1'b0;
  bit         m_prev  = 1'b0;
  bit         m_d     = 1'b0;
  int         m_k     = 0;
  int         m_n     = 0;
  logic       m_valid = 1'b0;
  logic [2:0] m_bin   = 3'b000;
  int         m_real  = 0;

  always @(posedge clk) begin : mdl
    bit e;
    e = tick && !m_prev;
    m_prev = reset ? 1'b0 : tick;
    if (reset) begin
      m_act = 1'b0;
      m_rep = 1'b0;
      m_valid = 1'b0;
      m_bin = 3'b000;
      m_real = 0;
    end else begin
      m_valid = 1'b0;
      if (!en) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        m_act = 1'b1;
        m_k = 0;
        m_n = 0;
        m_d = dir;
      end else if (m_rep) begin
        m_k = 1;
        m_n = int'(e);
        m_d = dir;
      end else if (dir != m_d) begin
        m_k = 0;
        m_n = 0;
        m_d = dir;
      end else begin
        m_k++;
        m_n += int'(e);
        if (m_k == WIN) begin
          m_valid = 1'b1;
          m_real = m_n;
          m_bin = {m_d, quant(m_n)};
        end
      end
      m_rep = m_valid;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", valid, m_valid);
      chk("bin_speed", bin_speed, m_bin);
      chk("real_speed", real_speed, m_real);
    end
  end

  int ph = 0;
  int kk = 0;

  // k rising edges per WIN cycles, one every two cycles.
  function automatic logic pat(int k, int i);
    return (i < 2 * k) && (i % 2 == 0);
  endfunction

  task automatic stepp();
    tick = pat(kk, ph % WIN);
    ph++;
    @(negedge clk);
  endtask

  task automatic until_valid(input string nm, output int n);
    n = 0;
    do begin
      stepp();
      n++;
    end while (!valid && n < 400);
    if (!valid) begin
      checks++;
      failures++;
      $display("FAIL %s timeout got=no_valid expected=valid", nm);
    end
  endtask

  task automatic run_k(input int k, input string nm, input logic [2:0] eb,
                       input int er);
    int n;
    kk = k;
    until_valid(nm, n);
    until_valid(nm, n);
    chk({nm, "_period"}, n, WIN);
    chk({nm, "_bin"}, bin_speed, eb);
    chk({nm, "_real"}, real_speed, er);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    en = 1'b0;
    tick = 1'b0;
    dir = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_bin", bin_speed, 0);
    chk("rst_real", real_speed, 0);

    reset = 1'b0;
    en = 1'b1;
    kk = 0;
    until_valid("first", n);
    chk("first_latency", n, 101);
    chk("idle_bin", bin_speed, 3'b000);
    chk("idle_real", real_speed, 0);
    until_valid("second", n);
    chk("idle_period", n, 100);

    dir = 1'b1;
    run_k(15, "k15", 3'b101, 15);
    run_k(10, "k10", 3'b101, 10);
    dir = 1'b0;
    run_k(30, "k30", 3'b010, 30);
    run_k(50, "k50", 3'b011, 50);
    run_k(24, "k24", 3'b001, 24);

    kk = 0;
    until_valid("quiet", n);
    until_valid("quiet", n);
    ph = 0;
    kk = 20;
    repeat (60) stepp();
    dir = 1'b1;
    tick = 1'b0;
    @(negedge clk);
    ph = 0;
    kk = 12;
    until_valid("flip", n);
    chk("flip_latency", n, 100);
    chk("flip_bin", bin_speed, 3'b101);
    chk("flip_real", real_speed, 12);

    ph = 0;
    kk = 10;
    until_valid("rep_edge", n);
    chk("rep_edge_period", n, 100);
    chk("rep_edge_real", real_speed, 10);
    chk("rep_edge_bin", bin_speed, 3'b101);

    ph = 0;
    kk = 15;
    repeat (50) stepp();
    reset = 1'b1;
    stepp();
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_bin", bin_speed, 3'b000);
    chk("mid_rst_real", real_speed, 0);
    reset = 1'b0;
    until_valid("after_rst", n);
    chk("after_rst_latency", n, 101);
    chk("after_rst_bin", bin_speed, 3'b101);
    chk("after_rst_real", real_speed, 15);

    repeat (50) stepp();
    en = 1'b0;
    repeat (5) stepp();
    chk("en_off_valid", valid, 0);
    chk("en_off_bin", bin_speed, 3'b101);
    chk("en_off_real", real_speed, 15);
    en = 1'b1;
    until_valid("reenable", n);
    chk("reenable_latency", n, 101);
    chk("reenable_real", real_speed, 15);

    repeat (3) @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
